// File: rtl/cga_char_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : cga_char_pixel_gen
// Purpose  : CGA character/graphics pixel generator sitting behind a
//            6845-style CRTC. On every character clock it latches the CRTC
//            address/row/enable/cursor and fetches two VRAM bytes. In text
//            mode it also fetches one font row. It then serialises 8 IRGB
//            pixels, MSB first, for the palette/scaler stage. Attribute
//            blink, cursor blink and the border colour are applied here.
// Ports    : CLOCK/RESET       system clock, synchronous active-high reset
//            CLKEN/PIXEL_CE    character enable / pixel enable (8 per char)
//            MA,RA,DE,CURSOR   CRTC outputs, latched on CLKEN
//            VSYNC             frame pulse driving the blink counter
//            gfx_mode,blink_en,border_color,pal_sel,pal_int  mode controls
//            vram_addr/rd/ack/din  VRAM read handshake (rd held until ack)
//            font_addr/font_din    character ROM (1-cycle read latency)
//            pixel             4-bit IRGB pixel index
//            underrun          sticky: a fetch was still in flight at CLKEN
// Revision : 1.0  initial release
// ============================================================================
module cga_char_pixel_gen #(
  parameter int FONT_ROWS  = 8,
  parameter int BLINK_BITS = 5
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CLKEN,
  input  logic        PIXEL_CE,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        DE,
  input  logic        CURSOR,
  input  logic        VSYNC,
  input  logic        gfx_mode,
  input  logic        blink_en,
  input  logic [3:0]  border_color,
  input  logic        pal_sel,
  input  logic        pal_int,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic        vram_ack,
  input  logic [7:0]  vram_din,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_din,
  output logic [3:0]  pixel,
  output logic        underrun
);

  localparam int c_ROW_BITS = $clog2(FONT_ROWS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FONT   = 3'd3,
    FWAIT  = 3'd4,
    READY  = 3'd5
  } state_t;

  state_t                r_state;
  logic [12:0]           r_ma;
  logic [2:0]            r_ra;
  logic                  r_de;
  logic                  r_cur;
  logic                  r_gfx;
  logic [7:0]            r_byte0;
  logic [7:0]            r_byte1;
  logic [7:0]            r_glyph;
  logic [10:0]           r_font_addr;
  logic                  r_underrun;
  logic [31:0]           r_shift;
  logic [3:0]            r_cnt;
  logic [3:0]            r_pixel;
  logic                  r_vs_d;
  logic [BLINK_BITS-1:0] r_blink;

  logic [13:0]           w_base;
  logic                  w_fetching;
  logic                  w_cur_phase;
  logic                  w_attr_phase;
  logic [3:0]            w_fg;
  logic [3:0]            w_bg;
  logic [3:0]            w_pix;
  logic [1:0]            w_idx;
  logic [15:0]           w_gsh;
  logic [7:0]            w_tsh;
  logic [31:0]           w_load;
  logic                  w_unused;

  // CRTC bits that have no meaning for a 16 KB CGA frame buffer.
  assign w_unused = ^{MA[13], RA[4:3]};

  // Graphics mode interleaves even/odd scan lines in two 8 KB banks.
  assign w_base = r_gfx ? {r_ra[0], r_ma[11:0], 1'b0} : {r_ma[12:0], 1'b0};

  assign w_fetching = (r_state == FETCH0) || (r_state == FETCH1);
  // Gating with RESET drops the request in the reset cycle itself, so the
  // memory never sees a request that would be ignored.
  assign vram_rd    = w_fetching && !RESET;
  assign vram_addr  = (r_state == FETCH1) ? (w_base + 14'd1) : w_base;
  assign font_addr  = r_font_addr;
  assign pixel      = r_pixel;
  assign underrun   = r_underrun;

  assign w_cur_phase  = r_blink[BLINK_BITS-2];
  assign w_attr_phase = r_blink[BLINK_BITS-1];

  // Fetch sequencer; CLKEN restarts it from any state.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_ma        <= '0;
      r_ra        <= '0;
      r_de        <= 1'b0;
      r_cur       <= 1'b0;
      r_gfx       <= 1'b0;
      r_byte0     <= '0;
      r_byte1     <= '0;
      r_glyph     <= '0;
      r_font_addr <= '0;
      r_underrun  <= 1'b0;
      r_vs_d      <= 1'b0;
      r_blink     <= '0;
    end else begin
      r_vs_d <= VSYNC;
      if (VSYNC && !r_vs_d) begin
        r_blink <= r_blink + 1'b1;
      end

      if (CLKEN) begin
        r_ma    <= MA[12:0];
        r_ra    <= RA[2:0];
        r_de    <= DE;
        r_cur   <= CURSOR;
        r_gfx   <= gfx_mode;
        r_state <= FETCH0;
        // IDLE is excluded: nothing was being fetched after reset.
        if (r_state != IDLE && r_state != READY) begin
          r_underrun <= 1'b1;
        end
      end else begin
        case (r_state)
          FETCH0: begin
            if (vram_ack) begin
              r_byte0 <= vram_din;
              r_state <= FETCH1;
            end
          end
          FETCH1: begin
            if (vram_ack) begin
              r_byte1 <= vram_din;
              if (r_gfx) begin
                r_state <= READY;
              end else begin
                // Presented during FONT; ROM data is valid in FWAIT.
                r_font_addr <= {r_byte0, r_ra[c_ROW_BITS-1:0]};
                r_state     <= FONT;
              end
            end
          end
          FONT: begin
            r_state <= FWAIT;
          end
          FWAIT: begin
            r_glyph <= font_din;
            r_state <= READY;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Colour for the 8 pixels of the character fetched in the previous
  // character period, packed MSB-first (pixel 0 in bits 31:28).
  always_comb begin
    w_bg = blink_en ? {1'b0, r_byte1[6:4]} : r_byte1[7:4];
    w_fg = r_byte1[3:0];
    if (blink_en && r_byte1[7] && !w_attr_phase) begin
      w_fg = w_bg;
    end
    w_gsh  = {r_byte0, r_byte1};
    w_tsh  = r_glyph;
    w_load = '0;
    w_idx  = '0;
    w_pix  = '0;
    for (int i = 0; i < 8; i++) begin
      w_idx = w_gsh[15:14];
      if (r_state != READY || !r_de) begin
        w_pix = border_color;
      end else if (r_gfx) begin
        w_pix = (w_idx == 2'd0) ? border_color : {pal_int, w_idx, pal_sel};
      end else if (r_cur && w_cur_phase) begin
        w_pix = w_fg;
      end else begin
        w_pix = w_tsh[7] ? w_fg : w_bg;
      end
      w_load = {w_load[27:0], w_pix};
      w_gsh  = {w_gsh[13:0], 2'b00};
      w_tsh  = {w_tsh[6:0], 1'b0};
    end
  end

  // Output shifter: loads on CLKEN, emits one pixel per PIXEL_CE and holds
  // the eighth pixel until the next load.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_pixel <= '0;
    end else if (CLKEN) begin
      if (PIXEL_CE) begin
        r_pixel <= w_load[31:28];
        r_shift <= {w_load[27:0], 4'h0};
        r_cnt   <= 4'd1;
      end else begin
        r_shift <= w_load;
        r_cnt   <= 4'd0;
      end
    end else if (PIXEL_CE && r_cnt != 4'd8) begin
      r_pixel <= r_shift[31:28];
      r_shift <= {r_shift[27:0], 4'h0};
      r_cnt   <= r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire
